// File: rtl/da_wave_gen.sv
// DDS waveform generator: divided sample tick, phase accumulator, external sine ROM,
// and a three-stage pipeline that shapes sine/saw/triangle/square samples for a DAC.
module da_wave_gen #(
   parameter int DATA_W  = 10,
   parameter int ROM_DW  = 8,
   parameter int PHASE_W = 10,
   parameter int ACC_W   = 16,
   parameter int DIV_W   = 8
) (
   input  logic               CLK_50M,
   input  logic               RST,
   input  logic               EN,
   input  logic [1:0]         MODE,
   input  logic [ACC_W-1:0]   FREQ_WORD,
   input  logic [DIV_W-1:0]   DIV,
   input  logic               CFG_LOAD,
   output logic [PHASE_W-1:0] rom_addr,
   input  logic [ROM_DW-1:0]  rom_q,
   output logic [DATA_W-1:0]  da_data,
   output logic               da_start,
   output logic               cfg_pending,
   output logic               wrap
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state_r, state_nxt;
   logic [DIV_W-1:0]     cnt_r, div_r, sh_div_r;
   logic [ACC_W-1:0]     acc_r, fw_r, sh_fw_r, acc_sum_s;
   logic [1:0]           mode_r, sh_mode_r;
   logic                 carry_s, work_s, tick_s, apply_s;
   logic [PHASE_W-1:0]   phase_s, p1_r, p2_r, p3_r;
   logic [1:0]           m1_r, m2_r, m3_r;
   logic                 v1_r, v2_r, v3_r;
   logic [ROM_DW-1:0]    q3_r;
   logic [PHASE_W-2:0]   tri_s;
   logic [DATA_W-1:0]    sample_s;

   function automatic logic [DATA_W-1:0] align_phase(input logic [PHASE_W-1:0] v);
      return DATA_W'({v, {DATA_W{1'b0}}} >> PHASE_W);
   endfunction

   function automatic logic [DATA_W-1:0] align_rom(input logic [ROM_DW-1:0] q);
      return DATA_W'({q, {DATA_W{1'b0}}} >> ROM_DW);
   endfunction

   // State register
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) state_r <= IDLE;
      else     state_r <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE:    if (EN) state_nxt = RUN;  else state_nxt = IDLE;
         RUN:     if (EN) state_nxt = RUN;  else state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A RUN cycle with EN already low is treated as idle so the outputs go quiet on the next edge.
   assign work_s               = (state_r == RUN) && EN;
   assign tick_s               = work_s && (cnt_r == div_r);
   assign phase_s              = acc_r[ACC_W-1 -: PHASE_W];
   assign {carry_s, acc_sum_s} = {1'b0, acc_r} + {1'b0, fw_r};
   assign apply_s              = cfg_pending && ((tick_s && carry_s) || (state_r == IDLE));

   // Sample shaping for the last pipeline stage
   always_comb begin
      sample_s = {DATA_W{1'b0}};
      if (p3_r[PHASE_W-1]) tri_s = ~p3_r[PHASE_W-2:0];
      else                 tri_s = p3_r[PHASE_W-2:0];
      case (m3_r)
         2'b00:   sample_s = align_rom(q3_r);
         2'b01:   sample_s = align_phase(p3_r);
         2'b10:   sample_s = align_phase({tri_s, 1'b0});
         2'b11:   sample_s = {DATA_W{~p3_r[PHASE_W-1]}};
         default: sample_s = {DATA_W{1'b0}};
      endcase
   end

   // Shadow capture and application of the configuration
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         sh_mode_r   <= 2'b00;
         sh_fw_r     <= {ACC_W{1'b0}};
         sh_div_r    <= {DIV_W{1'b0}};
         mode_r      <= 2'b00;
         fw_r        <= {ACC_W{1'b0}};
         div_r       <= {DIV_W{1'b0}};
         cfg_pending <= 1'b0;
      end else begin
         if (CFG_LOAD) begin
            sh_mode_r <= MODE;
            sh_fw_r   <= FREQ_WORD;
            sh_div_r  <= DIV;
         end
         if (apply_s) begin
            mode_r <= sh_mode_r;
            fw_r   <= sh_fw_r;
            div_r  <= sh_div_r;
         end
         if (CFG_LOAD)     cfg_pending <= 1'b1;
         else if (apply_s) cfg_pending <= 1'b0;
      end
   end

   // Divider, accumulator and ROM-latency-matched sample pipeline
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         cnt_r    <= {DIV_W{1'b0}};
         acc_r    <= {ACC_W{1'b0}};
         rom_addr <= {PHASE_W{1'b0}};
         p1_r     <= {PHASE_W{1'b0}};
         p2_r     <= {PHASE_W{1'b0}};
         p3_r     <= {PHASE_W{1'b0}};
         m1_r     <= 2'b00;
         m2_r     <= 2'b00;
         m3_r     <= 2'b00;
         v1_r     <= 1'b0;
         v2_r     <= 1'b0;
         v3_r     <= 1'b0;
         q3_r     <= {ROM_DW{1'b0}};
         da_data  <= {DATA_W{1'b0}};
         da_start <= 1'b0;
         wrap     <= 1'b0;
      end else if (work_s) begin
         cnt_r <= tick_s ? {DIV_W{1'b0}} : cnt_r + DIV_W'(1);
         if (tick_s) begin
            acc_r    <= acc_sum_s;
            rom_addr <= phase_s;
            p1_r     <= phase_s;
            m1_r     <= mode_r;
         end
         v1_r     <= tick_s;
         wrap     <= tick_s && carry_s;
         p2_r     <= p1_r;
         m2_r     <= m1_r;
         v2_r     <= v1_r;
         p3_r     <= p2_r;
         m3_r     <= m2_r;
         v3_r     <= v2_r;
         q3_r     <= rom_q;
         if (v3_r) da_data <= sample_s;
         da_start <= v3_r;
      end else begin
         cnt_r    <= {DIV_W{1'b0}};
         acc_r    <= {ACC_W{1'b0}};
         rom_addr <= {PHASE_W{1'b0}};
         v1_r     <= 1'b0;
         v2_r     <= 1'b0;
         v3_r     <= 1'b0;
         da_data  <= {DATA_W{1'b0}};
         da_start <= 1'b0;
         wrap     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_da_wave_gen.sv
// Directed bench for da_wave_gen: hand-computed latencies and sample sequences for
// every mode, config shadowing, EN drop/restart and asynchronous reset.
module tb_da_wave_gen;

   logic        clk = 1'b0;
   logic        RST, EN, CFG_LOAD;
   logic [1:0]  MODE;
   logic [15:0] FREQ_WORD;
   logic [7:0]  DIV;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_q;
   logic [9:0]  da_data;
   logic        da_start, cfg_pending, wrap;
   int          errors = 0;
   int          checks = 0;
   int          n;

   always #10 clk = ~clk;

   // Sine ROM model with one-cycle registered read, q = addr[7:0]
   always @(posedge clk) rom_q <= rom_addr[7:0];

   da_wave_gen dut (
      .CLK_50M(clk), .RST(RST), .EN(EN), .MODE(MODE), .FREQ_WORD(FREQ_WORD),
      .DIV(DIV), .CFG_LOAD(CFG_LOAD), .rom_addr(rom_addr), .rom_q(rom_q),
      .da_data(da_data), .da_start(da_start), .cfg_pending(cfg_pending), .wrap(wrap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget, output int cnt);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!da_start && cnt < budget);
   endtask

   task automatic load_cfg(input logic [1:0] m, input logic [15:0] fw, input logic [7:0] d);
      MODE = m; FREQ_WORD = fw; DIV = d; CFG_LOAD = 1'b1;
      step(1);
      CFG_LOAD = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_data"}, da_data, 0);
      chk({tag, "_start"}, da_start, 0);
      chk({tag, "_wrap"}, wrap, 0);
      chk({tag, "_addr"}, rom_addr, 0);
   endtask

   function automatic int saw_p(input int t);
      return (t < 1024) ? t : (2 * (t - 1024)) % 1024;
   endfunction

   function automatic int tri_v(input int p);
      return (p < 512) ? 2 * p : 2 * (1023 - p);
   endfunction

   initial begin
      RST = 1'b1; EN = 1'b0; CFG_LOAD = 1'b0; MODE = 2'b00; FREQ_WORD = 16'd0; DIV = 8'd0;
      #3;
      chk_quiet("rst");
      chk("rst_pend", cfg_pending, 0);
      step(2);
      RST = 1'b0;
      step(1);
      chk_quiet("idle");

      // Slow sawtooth: DIV=96, first sample 101 edges after EN, then every 97
      load_cfg(2'b01, 16'd64, 8'd96);
      chk("pend_set", cfg_pending, 1);
      step(1);
      chk("pend_idle_apply", cfg_pending, 0);
      EN = 1'b1;
      for (int s = 0; s < 3; s++) begin
         wait_start(200, n);
         chk("div96_gap", n, (s == 0) ? 101 : 97);
         chk("div96_data", da_data, s);
         chk("div96_wrap", wrap, 0);
      end
      EN = 1'b0;
      step(1);
      chk_quiet("drop1");

      // Fast sawtooth with a mid-period FW=128 reload applied at the wrap tick
      load_cfg(2'b01, 16'd64, 8'd0);
      step(1);
      EN = 1'b1;
      step(4);
      chk("saw_lat", da_start, 0);
      for (int k = 0; k <= 1030; k++) begin
         step(1);
         chk("saw_start", da_start, 1);
         chk("saw_data", da_data, saw_p(k));
         chk("saw_addr", rom_addr, saw_p(k + 3));
         chk("saw_wrap", wrap, (k == 1020) ? 1 : 0);
         chk("saw_pend", cfg_pending, (k >= 501 && k < 1020) ? 1 : 0);
         if (k == 500) begin
            MODE = 2'b01; FREQ_WORD = 16'd128; DIV = 8'd0; CFG_LOAD = 1'b1;
         end
         if (k == 501) CFG_LOAD = 1'b0;
      end

      // EN drop goes quiet on the next edge; re-enable restarts from P=0
      EN = 1'b0;
      step(1);
      chk_quiet("drop2");
      step(2);
      chk("drop2_silent", da_start, 0);
      EN = 1'b1;
      step(4);
      chk("restart_lat", da_start, 0);
      step(1);
      chk("restart_start", da_start, 1);
      chk("restart_d0", da_data, 0);
      step(1);
      chk("restart_d1", da_data, 2);

      // Triangle, one sample per clock
      EN = 1'b0;
      step(1);
      load_cfg(2'b10, 16'd64, 8'd0);
      step(1);
      EN = 1'b1;
      step(4);
      for (int k = 0; k <= 1025; k++) begin
         step(1);
         chk("tri_start", da_start, 1);
         chk("tri_data", da_data, tri_v(k % 1024));
      end

      // Square at half the table per tick: alternates high/low, wrap every other tick
      EN = 1'b0;
      step(1);
      load_cfg(2'b11, 16'h8000, 8'd0);
      step(1);
      EN = 1'b1;
      step(4);
      for (int k = 0; k < 8; k++) begin
         step(1);
         chk("sq_data", da_data, (k % 2 == 0) ? 1023 : 0);
         chk("sq_wrap", wrap, (k % 2 == 0) ? 1 : 0);
      end

      // Sine through the ROM model with DIV=2
      EN = 1'b0;
      step(1);
      load_cfg(2'b00, 16'd64, 8'd2);
      step(1);
      EN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_start(50, n);
         chk("sin_gap", n, (k == 0) ? 7 : 3);
         chk("sin_data", da_data, 4 * k);
         chk("sin_addr", rom_addr, k + 1);
      end
      load_cfg(2'b11, 16'd5, 8'd7);
      chk("sin_pend", cfg_pending, 1);

      // Asynchronous reset between edges clears everything at once
      #5;
      RST = 1'b1;
      #1;
      chk_quiet("arst");
      chk("arst_pend", cfg_pending, 0);
      #20;
      chk_quiet("arst_hold");
      @(posedge clk);
      #1;
      RST = 1'b0;
      // Reset config is sine with FW=0: frozen phase, constant output, da_start still pulsing
      step(4);
      chk("post_rst_lat", da_start, 0);
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk("frz_start", da_start, 1);
         chk("frz_data", da_data, 0);
         chk("frz_addr", rom_addr, 0);
         chk("frz_pend", cfg_pending, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
